// File: rtl/mem_access_unit_pkg.sv
// Shared opcode, state and byte-lane definitions for the load/store stage.
package mem_access_unit_pkg;

    typedef enum logic [5:0] {
        OP_ADDIU = 6'h09,
        OP_LB    = 6'h20,
        OP_LH    = 6'h21,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane placement for stores, lane extraction/extension for loads,
// and alignment checking. Purely combinational.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  opcode_t     opcode,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic        misaligned,
    output logic [31:0] load_data,
    output logic        is_load,
    output logic        is_store
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half-word out of the read word
    always_comb begin
        byte_s = readdata[{ea_lo, 3'b000} +: 8];
        if (ea_lo[1]) begin
            half_s = readdata[31:16];
        end else begin
            half_s = readdata[15:0];
        end
    end

    // Decode opcode into lane enables, store placement and load result
    always_comb begin
        byteenable = BE_WORD;
        writedata  = store_data;
        misaligned = 1'b0;
        load_data  = 32'h0000_0000;
        is_load    = 1'b0;
        is_store   = 1'b0;
        case (opcode)
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = (ea_lo != 2'b00);
                load_data  = readdata;
            end
            OP_LH: begin
                is_load    = 1'b1;
                misaligned = ea_lo[0];
                load_data  = sext16(half_s);
            end
            OP_LHU: begin
                is_load    = 1'b1;
                misaligned = ea_lo[0];
                load_data  = {16'h0000, half_s};
            end
            OP_LB: begin
                is_load   = 1'b1;
                load_data = sext8(byte_s);
            end
            OP_LBU: begin
                is_load   = 1'b1;
                load_data = {24'h00_0000, byte_s};
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = (ea_lo != 2'b00);
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = ea_lo[0];
                byteenable = ea_lo[1] ? BE_HI : BE_LO;
                writedata  = {2{store_data[15:0]}};
            end
            OP_SB: begin
                is_store   = 1'b1;
                byteenable = 4'b0001 << ea_lo;
                writedata  = {4{store_data[7:0]}};
            end
            default: begin
                is_load  = 1'b0;
                is_store = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: runs one Avalon-style transaction per request with
// waitrequest stalls and returns extended load data for write-back.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start_i,
    input  opcode_t           opcode_i,
    input  logic [ADDR_W-1:0] effective_address_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [4:0]        dest_reg_i,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [DATA_W-1:0] writedata_o,
    output logic [3:0]        byteenable_o,
    input  logic              waitrequest_i,
    input  logic [DATA_W-1:0] readdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              load_we_o,
    output logic [4:0]        dest_reg_o,
    output logic              misaligned_o
);

    mem_state_t        state_r;
    opcode_t           op_r;
    logic [1:0]        ea_lo_r;
    logic [ADDR_W-1:0] address_r;
    logic              read_r;
    logic              write_r;
    logic [DATA_W-1:0] writedata_r;
    logic [3:0]        byteenable_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] load_data_r;
    logic              load_we_r;
    logic [4:0]        dest_reg_r;
    logic              misaligned_r;

    opcode_t     align_op_s;
    logic [1:0]  align_ea_lo_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        mis_s;
    logic [31:0] load_s;
    logic        is_load_s;
    logic        is_store_s;

    // The aligner sees the incoming request in IDLE and the latched one after
    always_comb begin
        if (state_r == ST_IDLE) begin
            align_op_s    = opcode_i;
            align_ea_lo_s = effective_address_i[1:0];
        end else begin
            align_op_s    = op_r;
            align_ea_lo_s = ea_lo_r;
        end
    end

    mem_lane_align u_align (
        .opcode     (align_op_s),
        .ea_lo      (align_ea_lo_s),
        .store_data (store_data_i),
        .readdata   (readdata_i),
        .byteenable (be_s),
        .writedata  (wdata_s),
        .misaligned (mis_s),
        .load_data  (load_s),
        .is_load    (is_load_s),
        .is_store   (is_store_s)
    );

    // Transaction FSM; every output is a register updated on state changes
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_ADDIU;
            ea_lo_r      <= 2'b00;
            address_r    <= {ADDR_W{1'b0}};
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            writedata_r  <= {DATA_W{1'b0}};
            byteenable_r <= 4'b0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            load_data_r  <= {DATA_W{1'b0}};
            load_we_r    <= 1'b0;
            dest_reg_r   <= 5'd0;
            misaligned_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i && (is_load_s || is_store_s)) begin
                        op_r         <= opcode_i;
                        ea_lo_r      <= effective_address_i[1:0];
                        address_r    <= {effective_address_i[ADDR_W-1:2], 2'b00};
                        writedata_r  <= wdata_s;
                        byteenable_r <= be_s;
                        dest_reg_r   <= dest_reg_i;
                        busy_r       <= 1'b1;
                        // Misaligned requests skip the bus entirely
                        if (mis_s) begin
                            state_r      <= ST_DONE;
                            done_r       <= 1'b1;
                            misaligned_r <= 1'b1;
                            load_we_r    <= 1'b0;
                        end else begin
                            state_r <= ST_ACCESS;
                            read_r  <= is_load_s;
                            write_r <= is_store_s;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!waitrequest_i) begin
                        state_r      <= ST_DONE;
                        read_r       <= 1'b0;
                        write_r      <= 1'b0;
                        done_r       <= 1'b1;
                        misaligned_r <= 1'b0;
                        load_we_r    <= is_load_s;
                        if (is_load_s) begin
                            load_data_r <= load_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    load_we_r    <= 1'b0;
                    misaligned_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign address_o    = address_r;
    assign read_o       = read_r;
    assign write_o      = write_r;
    assign writedata_o  = writedata_r;
    assign byteenable_o = byteenable_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign load_data_o  = load_data_r;
    assign load_we_o    = load_we_r;
    assign dest_reg_o   = dest_reg_r;
    assign misaligned_o = misaligned_r;

endmodule
